// File: rtl/seq_mult.sv
// Sequential shift-and-add multiplier: one N-bit add per clock, product after N iterations.
// Unsigned operands, 2N-bit product held until the next completed operation.
module seq_mult #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [N-1:0]   mcand;
    logic [2*N:0]   p;
    logic [CW-1:0]  count;
    logic           last_iter;
    logic [N:0]     sum;
    logic [2*N:0]   p_step;

    assign last_iter = (count == CW'(N - 1));

    // One iteration: conditional add into the upper half (carry kept in bit 2N), then shift right.
    always_comb begin
        sum    = {1'b0, p[2*N-1:N]} + {1'b0, mcand};
        p_step = (p[0] ? {sum, p[N-1:0]} : p) >> 1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: defaulting state_nxt before the case keeps this block free of inferred latches.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode the state register only, so inputs never reach them combinationally.
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // NOTE: datapath registers are reset too, so an aborted operation leaves product at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand   <= '0;
            p       <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= a;
                        p     <= {{(N+1){1'b0}}, b};
                        count <= '0;
                    end
                end
                RUN: begin
                    p     <= p_step;
                    count <= count + CW'(1);
                    if (last_iter) begin
                        product <= p_step[2*N-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
